// File: rtl/pulse_monitor.sv
// Pulse length monitor: synchronizes an async pulse, measures its high
// time, counts valid pulses and flags glitches and saturation.
module pulse_monitor #(
  parameter int WIDTH   = 8,
  parameter int MIN_LEN = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             signal,
  input  logic             enable,
  output logic             done,
  output logic             glitch,
  output logic [WIDTH-1:0] last_len,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  localparam logic [WIDTH-1:0] MAX   = '1;
  localparam logic [WIDTH-1:0] MIN_L = WIDTH'(MIN_LEN);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic             meta;
  logic             sync;
  logic             prev;
  logic [0:0]       state;
  logic [WIDTH-1:0] len;
  logic             rise;

  assign rise = sync & ~prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta     <= 1'b0;
      sync     <= 1'b0;
      prev     <= 1'b0;
      state    <= IDLE;
      len      <= '0;
      last_len <= '0;
      count    <= '0;
      sat      <= 1'b0;
      done     <= 1'b0;
      glitch   <= 1'b0;
    end else begin
      meta   <= signal;
      sync   <= meta;
      prev   <= sync;
      done   <= 1'b0;
      glitch <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise && enable) begin
            state <= MEASURE;
            len   <= ONE;
          end
        end
        MEASURE: begin
          // abort wins over a same-cycle fall; re-arm only on a fresh rise
          if (!enable) begin
            state <= IDLE;
          end else if (!sync) begin
            state    <= IDLE;
            done     <= 1'b1;
            last_len <= len;
            if (len >= MIN_L) begin
              if (count != MAX) count <= count + ONE;
              if (count >= MAX - ONE) sat <= 1'b1;
            end else begin
              glitch <= 1'b1;
            end
          end else begin
            if (len != MAX) len <= len + ONE;
            if (len >= MAX - ONE) sat <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_monitor.sv
// Bench for pulse_monitor: vector table, corner sequences and a
// randomized run against a history-based reference model.
module tb_pulse_monitor;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst8, sig8, en8, done8, gl8, sat8;
  logic [7:0] last8, cnt8;
  logic       rst4, sig4, en4, done4, gl4, sat4;
  logic [3:0] last4, cnt4;

  pulse_monitor #(.WIDTH(8), .MIN_LEN(2)) dut8 (
    .clock(clock), .reset(rst8), .signal(sig8), .enable(en8),
    .done(done8), .glitch(gl8), .last_len(last8), .count(cnt8),
    .sat(sat8));

  pulse_monitor #(.WIDTH(4), .MIN_LEN(2)) dut4 (
    .clock(clock), .reset(rst4), .signal(sig4), .enable(en4),
    .done(done4), .glitch(gl4), .last_len(last4), .count(cnt4),
    .sat(sat4));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [18:0] out8();
    return {done8, gl8, last8, cnt8, sat8};
  endfunction

  typedef struct {
    bit rst, sig, en, done, gl;
    int last, cnt;
    bit sat;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit e, bit d, bit g,
                              int l, int c, bit st);
    vec_t v;
    v.rst = r; v.sig = s; v.en = e; v.done = d; v.gl = g;
    v.last = l; v.cnt = c; v.sat = st;
    return v;
  endfunction

  // reference model: sync is the input two samples back, prev three back
  bit q[$];
  bit m_meas, m_done, m_gl, m_sat;
  int m_len, m_last, m_cnt;

  function automatic bit hq(int back);
    if (q.size() >= back) return q[q.size() - back];
    return 1'b0;
  endfunction

  task automatic model_edge(bit r, bit s, bit e);
    bit sy, pv;
    sy = hq(2);
    pv = hq(3);
    if (r) begin
      q.delete();
      m_meas = 0; m_done = 0; m_gl = 0; m_sat = 0;
      m_len = 0; m_last = 0; m_cnt = 0;
      return;
    end
    m_done = 0;
    m_gl   = 0;
    if (!m_meas) begin
      if (sy && !pv && e) begin
        m_meas = 1;
        m_len  = 1;
      end
    end else if (!e) begin
      m_meas = 0;
    end else if (!sy) begin
      m_meas = 0;
      m_done = 1;
      m_last = m_len;
      if (m_len >= 2) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt == 255) m_sat = 1;
      end else begin
        m_gl = 1;
      end
    end else begin
      if (m_len < 255) m_len++;
      if (m_len == 255) m_sat = 1;
    end
    q.push_back(s);
    if (q.size() > 4) void'(q.pop_front());
  endtask

  vec_t tv[37];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nd, ngl, dj;
    rst8 = 1; sig8 = 0; en8 = 1;
    rst4 = 1; sig4 = 0; en4 = 1;

    tv[0]  = mk(1,0,1, 0,0,0,0,0);
    tv[1]  = mk(0,1,1, 0,0,0,0,0);
    tv[2]  = mk(0,1,1, 0,0,0,0,0);
    tv[3]  = mk(0,1,1, 0,0,0,0,0);
    tv[4]  = mk(0,1,1, 0,0,0,0,0);
    tv[5]  = mk(0,1,1, 0,0,0,0,0);
    tv[6]  = mk(0,0,1, 0,0,0,0,0);
    tv[7]  = mk(0,0,1, 0,0,0,0,0);
    tv[8]  = mk(0,0,1, 1,0,5,1,0);
    tv[9]  = mk(0,0,1, 0,0,5,1,0);
    tv[10] = mk(0,1,1, 0,0,5,1,0);
    tv[11] = mk(0,0,1, 0,0,5,1,0);
    tv[12] = mk(0,0,1, 0,0,5,1,0);
    tv[13] = mk(0,0,1, 1,1,1,1,0);
    tv[14] = mk(0,0,1, 0,0,1,1,0);
    tv[15] = mk(0,1,0, 0,0,1,1,0);
    tv[16] = mk(0,1,0, 0,0,1,1,0);
    tv[17] = mk(0,0,0, 0,0,1,1,0);
    tv[18] = mk(0,0,1, 0,0,1,1,0);
    tv[19] = mk(0,0,1, 0,0,1,1,0);
    tv[20] = mk(0,0,1, 0,0,1,1,0);
    tv[21] = mk(0,1,1, 0,0,1,1,0);
    tv[22] = mk(0,1,1, 0,0,1,1,0);
    tv[23] = mk(0,0,1, 0,0,1,1,0);
    tv[24] = mk(0,0,1, 0,0,1,1,0);
    tv[25] = mk(0,0,1, 1,0,2,2,0);
    tv[26] = mk(0,0,1, 0,0,2,2,0);
    tv[27] = mk(0,1,1, 0,0,2,2,0);
    tv[28] = mk(0,1,1, 0,0,2,2,0);
    tv[29] = mk(0,0,1, 0,0,2,2,0);
    tv[30] = mk(0,1,1, 0,0,2,2,0);
    tv[31] = mk(0,1,1, 1,0,2,3,0);
    tv[32] = mk(0,1,1, 0,0,2,3,0);
    tv[33] = mk(0,0,1, 0,0,2,3,0);
    tv[34] = mk(0,0,1, 0,0,2,3,0);
    tv[35] = mk(0,0,1, 1,0,3,4,0);
    tv[36] = mk(0,0,1, 0,0,3,4,0);

    for (int i = 0; i < 37; i++) begin
      rst8 = tv[i].rst; sig8 = tv[i].sig; en8 = tv[i].en;
      tick();
      check($sformatf("vec%0d", i), 32'(out8()),
            32'({tv[i].done, tv[i].gl, 8'(tv[i].last),
                 8'(tv[i].cnt), tv[i].sat}));
    end

    // enable dropped mid-pulse: abort, no re-arm while still high
    nd = 0;
    for (int j = 0; j < 16; j++) begin
      sig8 = (j < 6); en8 = (j != 4);
      tick();
      if (done8) nd++;
    end
    check("abort_no_done", 32'(nd), 0);
    check("abort_last", 32'(last8), 3);
    check("abort_cnt", 32'(cnt8), 4);

    // enable drop on the same cycle the pulse ends
    nd = 0;
    for (int j = 0; j < 11; j++) begin
      sig8 = (j < 3); en8 = (j != 5);
      tick();
      if (done8) nd++;
    end
    check("fall_abort_no_done", 32'(nd), 0);
    check("fall_abort_cnt", 32'(cnt8), 4);

    nd = 0; ngl = 0;
    for (int j = 0; j < 13; j++) begin
      sig8 = (j < 4); en8 = 1;
      tick();
      if (done8) nd++;
      if (gl8) ngl++;
    end
    check("resume_done", 32'(nd), 1);
    check("resume_glitch", 32'(ngl), 0);
    check("resume_last", 32'(last8), 4);
    check("resume_cnt", 32'(cnt8), 5);

    // reset in the middle of a pulse that stays high afterwards
    for (int j = 0; j < 3; j++) begin
      sig8 = 1; en8 = 1;
      tick();
    end
    rst8 = 1; sig8 = 1;
    tick();
    check("midrst_zero", 32'(out8()), 0);
    rst8 = 0;
    nd = 0; dj = -1;
    for (int j = 1; j <= 12; j++) begin
      sig8 = (j <= 4);
      tick();
      if (done8) begin
        nd++;
        dj = j;
      end
    end
    check("midrst_done", 32'(nd), 1);
    check("midrst_done_cycle", 32'(dj), 7);
    check("midrst_last", 32'(last8), 4);
    check("midrst_cnt", 32'(cnt8), 1);

    // length saturation on the narrow instance
    rst4 = 1; sig4 = 0; en4 = 1;
    tick();
    check("w4_reset", 32'({done4, gl4, last4, cnt4, sat4}), 0);
    rst4 = 0;
    nd = 0;
    for (int j = 0; j < 20; j++) begin
      sig4 = 1;
      tick();
      if (done4) nd++;
    end
    check("w4_len_sat_flag", 32'(sat4), 1);
    check("w4_len_no_done", 32'(nd), 0);
    for (int j = 0; j < 10; j++) begin
      sig4 = 0;
      tick();
      if (done4) nd++;
    end
    check("w4_len_done", 32'(nd), 1);
    check("w4_len_last", 32'(last4), 15);
    check("w4_len_cnt", 32'(cnt4), 1);

    // count saturation
    rst4 = 1;
    tick();
    rst4 = 0;
    nd = 0;
    for (int p = 0; p < 17; p++) begin
      for (int j = 0; j < 5; j++) begin
        sig4 = (j < 3);
        tick();
        if (done4) nd++;
      end
      if (p == 13) begin
        for (int j = 0; j < 3; j++) begin
          sig4 = 0;
          tick();
          if (done4) nd++;
        end
        check("w4_cnt14", 32'(cnt4), 14);
        check("w4_cnt14_sat", 32'(sat4), 0);
      end
    end
    for (int j = 0; j < 6; j++) begin
      sig4 = 0;
      tick();
      if (done4) nd++;
    end
    check("w4_cnt_dones", 32'(nd), 17);
    check("w4_cnt_hold", 32'(cnt4), 15);
    check("w4_cnt_sat", 32'(sat4), 1);

    // randomized run against the model
    rst8 = 1; sig8 = 0; en8 = 1;
    tick();
    model_edge(1, 0, 1);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(2, 0) == 0) sig8 = ~sig8;
      en8  = ($urandom_range(15, 0) != 0);
      rst8 = ($urandom_range(199, 0) == 0);
      tick();
      model_edge(rst8, sig8, en8);
      check($sformatf("rand%0d", i), 32'(out8()),
            32'({m_done, m_gl, 8'(m_last), 8'(m_cnt), m_sat}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_monitor.md
PULSE_MONITOR -- requirements
Module: pulse_monitor

Interface
REQ-001 Parameter WIDTH, default 8: width of the length and count registers.
REQ-002 Parameter MIN_LEN, default 2: minimum high length, in clock cycles, for a pulse to count as valid.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port signal, input, 1: asynchronous pulse input, driven by the trigger/pulse stage.
REQ-006 Port enable, input, 1: when high, pulses are measured.
REQ-007 Port done, output, 1: one-cycle strobe marking the end of a measured pulse.
REQ-008 Port glitch, output, 1: one-cycle strobe, coincident with done, when the pulse was shorter than MIN_LEN.
REQ-009 Port last_len, output, WIDTH: high length, in cycles, of the most recently completed pulse.
REQ-010 Port count, output, WIDTH: number of valid pulses since reset.
REQ-011 Port sat, output, 1: sticky flag, set when count or the length counter saturates.

Function
REQ-012 signal SHALL pass through a 2-flop synchronizer; sync denotes the second flop output; all logic uses sync only.
REQ-013 A rise SHALL be detected when sync=1 and its previous-cycle value was 0; response latency is 2 cycles from signal sampling to rise.
REQ-014 The FSM SHALL have two states: IDLE and MEASURE.
REQ-015 IDLE: on rise with enable=1, go to MEASURE and load len=1; on rise with enable=0, stay in IDLE.
REQ-016 MEASURE: while sync=1, len increments by 1, saturating at 2^WIDTH-1; reaching saturation sets sat.
REQ-017 MEASURE with sync=0 SHALL return to IDLE and, on that same edge, load last_len=len and assert done for exactly one cycle.
REQ-018 On completion with len >= MIN_LEN, count SHALL increment by 1, saturating at 2^WIDTH-1 (saturation sets sat); otherwise glitch=1 and count is unchanged.
REQ-019 enable falling to 0 in MEASURE SHALL abort to IDLE: no done, no glitch, and last_len and count unchanged.
REQ-020 When sync falls and enable falls on the same cycle in MEASURE, the abort takes priority.
REQ-021 A pulse still high when abort or saturation occurs SHALL NOT re-arm until sync returns low and rises again.
REQ-022 done and glitch SHALL be registered outputs, with no combinational path from signal or enable.
REQ-023 Back-to-back pulses separated by one low cycle of sync SHALL each be measured.

Reset
REQ-024 reset=1 at a clock edge SHALL force: FSM=IDLE, both synchronizer flops=0, previous sync=0, len=0, last_len=0, count=0, sat=0, done=0, glitch=0.
REQ-025 reset asserted mid-MEASURE SHALL discard the pulse with no done; if signal is still high after release, the synchronizer's 0 history makes it detected as a new rise.
REQ-026 reset SHALL take priority over every other input.

Verification
REQ-027 Reset, enable=1, signal high for 5 cycles then low -> one done pulse, last_len=5, count=1, glitch=0.
REQ-028 signal high 1 cycle, MIN_LEN=2 -> done=1 with glitch=1, last_len=1, count remains 0.
REQ-029 enable dropped on the 3rd high cycle of a 6-cycle pulse -> no done, count and last_len unchanged, no re-measure until the next rise.
REQ-030 WIDTH=4, signal held high for 20 cycles -> len saturates at 15, sat=1, on fall last_len=15, count=1.
REQ-031 WIDTH=4, 17 valid 3-cycle pulses -> count holds at 15, sat=1, done asserted 17 times.
REQ-032 reset asserted in the middle of a pulse with signal still high after release -> outputs zeroed, then one rise detected 2 cycles after release and measured normally.
